conv_stream_host: RTL and testbench

CONV_STREAM_HOST -- requirements
Module: conv_stream_host

---
 rtl/conv_stream_host.sv | 168 ++++++++++++++++
 tb/tb_conv_stream_host.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_host.sv
// conv_stream_host
//   Frame sequencer that sits between an upstream loader, a streaming
//   convolution engine and a downstream result consumer.  One frame at a
//   time: LENX x words are buffered from the loader, streamed to the engine,
//   LENY y words are collected back from the engine (collection may overlap
//   the x stream), then the y words are presented to the consumer in order.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   ld_data/valid/ready    x words in from the loader          (LOAD)
//   m_data_x/valid/ready   x words out to the conv engine      (SEND)
//   s_data_y/valid/ready   y words in from the conv engine     (SEND, DRAIN)
//   r_data/valid/ready     y words out to the consumer         (OUT)
//   busy                   low only when idle in LOAD with nothing loaded
module conv_stream_host #(
  parameter int WIDTH = 16,
  parameter int LENX  = 16,
  parameter int LENY  = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  output logic [WIDTH-1:0] m_data_x,
  output logic             m_valid_x,
  input  logic             m_ready_x,
  input  logic [WIDTH-1:0] s_data_y,
  input  logic             s_valid_y,
  output logic             s_ready_y,
  output logic [WIDTH-1:0] r_data,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             busy
);

  localparam int XW = (LENX > 1) ? $clog2(LENX) : 1;
  localparam int YW = $clog2(LENY) + 1;
  // Index width for ybuf; the y counters carry one extra bit so they can
  // hold the value LENY itself.
  localparam int YI = (LENY > 1) ? $clog2(LENY) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(LENX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(LENY - 1);
  localparam logic [YW-1:0] Y_FULL = YW'(LENY);

  typedef enum logic [1:0] {
    LOAD,
    SEND,
    DRAIN,
    OUT
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   ld_cnt_q, ld_cnt_d;
  logic [XW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [YW-1:0]   ry_cnt_q, ry_cnt_d;
  logic [YW-1:0]   out_cnt_q, out_cnt_d;

  logic [WIDTH-1:0] xbuf_q [LENX];
  logic [WIDTH-1:0] ybuf_q [LENY];

  logic ld_hs, x_hs, y_hs, r_hs;

  // Handshake qualifiers are purely state-driven, so no valid output ever
  // depends on its own ready input.
  always_comb begin
    ld_ready  = (state_q == LOAD);
    m_valid_x = (state_q == SEND);
    s_ready_y = ((state_q == SEND) || (state_q == DRAIN)) && (ry_cnt_q < Y_FULL);
    r_valid   = (state_q == OUT);
    busy      = !((state_q == LOAD) && (ld_cnt_q == '0));
    m_data_x  = xbuf_q[tx_cnt_q];
    r_data    = ybuf_q[out_cnt_q[YI-1:0]];
  end

  assign ld_hs = ld_valid  && ld_ready;
  assign x_hs  = m_valid_x && m_ready_x;
  assign y_hs  = s_valid_y && s_ready_y;
  assign r_hs  = r_valid   && r_ready;

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    tx_cnt_d  = tx_cnt_q;
    ry_cnt_d  = ry_cnt_q;
    out_cnt_d = out_cnt_q;

    // y capture is independent of the x stream so both may land together.
    if (y_hs) begin
      ry_cnt_d = ry_cnt_q + YW'(1);
    end

    unique case (state_q)
      LOAD: begin
        if (ld_hs) begin
          if (ld_cnt_q == X_LAST) begin
            ld_cnt_d = '0;
            state_d  = SEND;
          end else begin
            ld_cnt_d = ld_cnt_q + XW'(1);
          end
        end
      end
      SEND: begin
        if (x_hs) begin
          if (tx_cnt_q == X_LAST) begin
            // tx_cnt parks on the last index (it would wrap otherwise) and
            // is cleared with the other counters at the end of OUT.  The y
            // count includes a same-cycle capture so DRAIN is never entered
            // with nothing left to drain.
            state_d = (ry_cnt_d == Y_FULL) ? OUT : DRAIN;
          end else begin
            tx_cnt_d = tx_cnt_q + XW'(1);
          end
        end
      end
      DRAIN: begin
        if (y_hs && (ry_cnt_q == Y_LAST)) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (r_hs) begin
          if (out_cnt_q == Y_LAST) begin
            tx_cnt_d  = '0;
            ry_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = LOAD;
          end else begin
            out_cnt_d = out_cnt_q + YW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOAD;
      ld_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      ry_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      ry_cnt_q  <= ry_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Frame buffers carry no reset; stale contents are never read because the
  // counters restart from zero.
  always_ff @(posedge clk) begin
    if (ld_hs && !reset) begin
      xbuf_q[ld_cnt_q] <= ld_data;
    end
    if (y_hs && !reset) begin
      ybuf_q[ry_cnt_q[YI-1:0]] <= s_data_y;
    end
  end

endmodule

// File: tb/tb_conv_stream_host.sv
`timescale 1ns/1ps
module tb_conv_stream_host;

  localparam int WIDTH = 16;
  localparam int LENX  = 16;
  localparam int LENY  = 13;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] ld_data;
  logic             ld_valid;
  logic             ld_ready;
  logic [WIDTH-1:0] m_data_x;
  logic             m_valid_x;
  logic             m_ready_x;
  logic [WIDTH-1:0] s_data_y;
  logic             s_valid_y;
  logic             s_ready_y;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ready;
  logic             busy;

  always #5 clk = ~clk;

  conv_stream_host #(
    .WIDTH(WIDTH),
    .LENX (LENX),
    .LENY (LENY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_data  (ld_data),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .m_data_x (m_data_x),
    .m_valid_x(m_valid_x),
    .m_ready_x(m_ready_x),
    .s_data_y (s_data_y),
    .s_valid_y(s_valid_y),
    .s_ready_y(s_ready_y),
    .r_data   (r_data),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: how many words of the current frame have been loaded,
  // sent, captured and output, plus the words themselves.
  int m_ld = 0, m_tx = 0, m_ry = 0, m_out = 0, frames_done = 0;
  logic [WIDTH-1:0] mx [LENX];
  logic [WIDTH-1:0] my [LENY];

  logic [WIDTH-1:0] ld_src[$], y_src[$], x_seen[$], r_seen[$], exp_q[$];
  logic [WIDTH-1:0] dummy;
  bit ld_en = 0, y_en = 0, mr_toggle = 0;
  bit hs_ld, hs_y;

  typedef struct {
    logic             rst;
    logic             ldv;
    logic [WIDTH-1:0] ldd;
    logic             syv;
    logic [WIDTH-1:0] syd;
    logic [4:0]       exp_ctl;   // {ld_ready, m_valid_x, s_ready_y, r_valid, busy}
  } vec_t;
  vec_t tbl [6];

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endfunction

  // One clock: compare outputs with the model, predict handshakes, advance.
  task automatic cyc_core();
    bit e_load, e_send, e_out, e_sry, hx, hr;
    logic [WIDTH-1:0] ldd, yd;
    #1;
    e_load = (m_ld < LENX);
    e_send = !e_load && (m_tx < LENX);
    e_out  = !e_load && (m_tx == LENX) && (m_ry == LENY);
    e_sry  = !e_load && (m_ry < LENY);
    chk("ctl", {27'd0, ld_ready, m_valid_x, s_ready_y, r_valid, busy},
        {27'd0, e_load, e_send, e_sry, e_out, !(e_load && (m_ld == 0))});
    if (e_send) chk("m_data_x", 32'(m_data_x), 32'(mx[m_tx]));
    if (e_out)  chk("r_data", 32'(r_data), 32'(my[m_out]));
    if (!reset && m_valid_x && m_ready_x) x_seen.push_back(m_data_x);
    if (!reset && r_valid && r_ready) r_seen.push_back(r_data);
    hs_ld = !reset && ld_valid && e_load;
    hx    = !reset && m_ready_x && e_send;
    hs_y  = !reset && s_valid_y && e_sry;
    hr    = !reset && r_ready && e_out;
    ldd   = ld_data;
    yd    = s_data_y;
    @(posedge clk);
    #1;
    if (reset) begin
      m_ld = 0; m_tx = 0; m_ry = 0; m_out = 0;
    end else begin
      if (hs_ld) begin mx[m_ld] = ldd; m_ld++; end
      if (hx) m_tx++;
      if (hs_y) begin my[m_ry] = yd; m_ry++; end
      if (hr) begin
        m_out++;
        if (m_out == LENY) begin
          m_ld = 0; m_tx = 0; m_ry = 0; m_out = 0;
          frames_done++;
        end
      end
    end
  endtask

  task automatic step();
    if (mr_toggle) m_ready_x = ~m_ready_x;
    ld_valid  = ld_en && (ld_src.size() > 0);
    ld_data   = ld_valid ? ld_src[0] : WIDTH'($urandom);
    s_valid_y = y_en && (y_src.size() > 0);
    s_data_y  = s_valid_y ? y_src[0] : WIDTH'($urandom);
    cyc_core();
    if (hs_ld) dummy = ld_src.pop_front();
    if (hs_y)  dummy = y_src.pop_front();
  endtask

  task automatic run_until_tx(int n);
    for (int c = 0; c < 400 && m_tx < n; c++) step();
    chk("tx_reached", 32'(m_tx >= n), 32'd1);
  endtask

  task automatic run_frame();
    int f0;
    f0 = frames_done;
    for (int c = 0; c < 600 && frames_done == f0; c++) step();
    chk("frame_done", 32'(frames_done != f0), 32'd1);
  endtask

  task automatic chk_seq(string name, logic [WIDTH-1:0] got[$], logic [WIDTH-1:0] exp[$]);
    chk(name, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(name, 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic load_src(int base);
    ld_src.delete();
    for (int i = 0; i < LENX; i++) ld_src.push_back(WIDTH'(base + i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'b10000};
    tbl[1] = '{1'b0, 1'b1, 16'h00A1, 1'b0, 16'h0000, 5'b10000};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h7FFF, 5'b10001};
    tbl[3] = '{1'b0, 1'b1, 16'h00A2, 1'b1, 16'h8000, 5'b10001};
    tbl[4] = '{1'b1, 1'b1, 16'h00A3, 1'b0, 16'h0000, 5'b10001};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'b10000};

    reset = 1'b1; ld_valid = 0; ld_data = '0; m_ready_x = 0;
    s_valid_y = 0; s_data_y = '0; r_ready = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state, first loads, y ignored in LOAD, reset priority over ld.
    for (int i = 0; i < 6; i++) begin
      reset     = tbl[i].rst;
      ld_valid  = tbl[i].ldv;
      ld_data   = tbl[i].ldd;
      s_valid_y = tbl[i].syv;
      s_data_y  = tbl[i].syd;
      #1;
      chk("tbl_ctl", {27'd0, ld_ready, m_valid_x, s_ready_y, r_valid, busy},
          {27'd0, tbl[i].exp_ctl});
      cyc_core();
    end
    reset = 1'b0;

    // Basic frame: x 1..16, y 100..112 after the x stream.
    load_src(1); ld_en = 1; y_en = 0; m_ready_x = 1; r_ready = 1;
    x_seen.delete(); r_seen.delete();
    run_until_tx(LENX);
    y_src.delete();
    for (int i = 0; i < LENY; i++) y_src.push_back(WIDTH'(100 + i));
    y_en = 1;
    run_frame();
    exp_q.delete();
    for (int i = 0; i < LENX; i++) exp_q.push_back(WIDTH'(1 + i));
    chk_seq("basic_x", x_seen, exp_q);
    exp_q.delete();
    for (int i = 0; i < LENY; i++) exp_q.push_back(WIDTH'(100 + i));
    chk_seq("basic_r", r_seen, exp_q);
    chk("ld_ready_after", 32'(ld_ready), 32'd1);
    y_en = 0;

    // m_ready_x alternating: each x held while stalled, no dups/skips.
    load_src(200); x_seen.delete(); r_seen.delete();
    m_ready_x = 0; mr_toggle = 1;
    run_until_tx(LENX);
    mr_toggle = 0; m_ready_x = 1;
    for (int i = 0; i < LENY; i++) y_src.push_back(WIDTH'($urandom));
    y_en = 1;
    run_frame();
    y_en = 0;
    exp_q.delete();
    for (int i = 0; i < LENX; i++) exp_q.push_back(WIDTH'(200 + i));
    chk_seq("stall_x", x_seen, exp_q);

    // y interleaved from the 5th x handshake; DRAIN skipped.
    load_src(300); x_seen.delete(); r_seen.delete();
    run_until_tx(4);
    exp_q.delete();
    for (int i = 0; i < LENY; i++) exp_q.push_back(WIDTH'(16'h0400 + i));
    y_src = exp_q;
    y_en = 1; m_ready_x = 0; mr_toggle = 1;
    run_until_tx(LENX);
    chk("drain_skip_rvalid", 32'(r_valid), 32'd1);
    chk("drain_skip_sready", 32'(s_ready_y), 32'd0);
    mr_toggle = 0; m_ready_x = 1; y_en = 0;
    run_frame();
    chk_seq("interleave_r", r_seen, exp_q);

    // Extreme values through DRAIN, then a 10-cycle r_ready stall with
    // y and ld offered but not accepted.
    load_src(16'h0A00); r_seen.delete();
    run_until_tx(LENX);
    exp_q.delete();
    exp_q.push_back(16'h7FFF);
    exp_q.push_back(16'h8000);
    for (int i = 2; i < LENY; i++) exp_q.push_back(WIDTH'(16'h0C00 + i));
    y_src = exp_q; y_en = 1;
    for (int c = 0; c < 200 && m_ry < LENY; c++) step();
    chk("drain_full", 32'(m_ry), 32'(LENY));
    r_ready = 0;
    y_src.delete(); y_src.push_back(16'h7FFF); y_src.push_back(16'h8000);
    load_src(16'h0B00);
    for (int i = 0; i < 10; i++) begin
      chk("stall_rvalid", 32'(r_valid), 32'd1);
      chk("stall_rdata", 32'(r_data), 32'h7FFF);
      chk("stall_sready", 32'(s_ready_y), 32'd0);
      chk("stall_ldready", 32'(ld_ready), 32'd0);
      step();
    end
    chk("y_ignored", 32'(y_src.size()), 32'd2);
    chk("ld_ignored", 32'(ld_src.size()), 32'(LENX));
    y_en = 0; y_src.delete(); ld_src.delete();
    r_ready = 1;
    run_frame();
    chk_seq("extreme_r", r_seen, exp_q);

    // Reset in SEND after 7 x handshakes, then a fresh frame 50..65.
    load_src(30);
    run_until_tx(7);
    reset = 1;
    step();
    reset = 0;
    chk("rst_mvalid", 32'(m_valid_x), 32'd0);
    chk("rst_rvalid", 32'(r_valid), 32'd0);
    chk("rst_ldready", 32'(ld_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    load_src(50); x_seen.delete(); y_src.delete();
    run_until_tx(LENX);
    for (int i = 0; i < LENY; i++) y_src.push_back(WIDTH'($urandom));
    y_en = 1;
    run_frame();
    y_en = 0;
    exp_q.delete();
    for (int i = 0; i < LENX; i++) exp_q.push_back(WIDTH'(50 + i));
    chk_seq("fresh_x", x_seen, exp_q);

    // Randomised traffic against the model, with occasional resets.
    begin
      int f0;
      f0 = frames_done;
      for (int c = 0; c < 3000; c++) begin
        m_ready_x = ($urandom_range(0, 1) == 1);
        r_ready   = ($urandom_range(0, 3) != 0);
        ld_en     = ($urandom_range(0, 3) != 0);
        y_en      = ($urandom_range(0, 1) == 1);
        reset     = ($urandom_range(0, 399) == 0);
        while (ld_src.size() < 2) ld_src.push_back(WIDTH'($urandom));
        while (y_src.size() < 2) y_src.push_back(WIDTH'($urandom));
        step();
      end
      reset = 0;
      chk("random_progress", 32'(frames_done > f0), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
